// File: rtl/jpeg_stream_packer.sv
// Packs variable-length Huffman codes MSB-first into BUS_W-bit flash words with 1-padding and partial-word flush.
// Define JPEG_BYTE_STUFF_EN to insert a 0x00 after every emitted 0xFF byte.
module jpeg_stream_packer #(
  parameter int BUS_W  = 32,
  parameter int CODE_W = 28,
  parameter int SIZE_W = 5
) (
  input  logic                     clk_in,
  input  logic                     rst,
  input  logic [CODE_W+SIZE_W-1:0] fifo_rd_data,
  input  logic                     fifo_empty,
  output logic                     fifo_rd,
  input  logic                     eof_in,
  input  logic                     halt,
  output logic [BUS_W-1:0]         write_data,
  output logic [BUS_W/8-1:0]       write_be,
  output logic                     d_qual,
  output logic                     eof_out
);
  localparam int ACC_W = CODE_W + 16;
  localparam int NB    = BUS_W / 8;
  localparam int CNT_W = $clog2(ACC_W + 1);
  localparam int AC_W  = $clog2(NB);

  typedef enum logic [1:0] {S_RUN, S_PAD, S_FLUSH, S_DONE} state_t;

  state_t           r_state;
  logic [ACC_W-1:0] r_acc_p0;
  logic [CNT_W-1:0] r_cnt_p0;
  logic [7:0]       r_byte_p1;
  logic             r_vld_p1;
  logic [BUS_W-1:0] r_asm_p2;
  logic [AC_W-1:0]  r_acnt_p2;
  logic             r_last;

  logic [CODE_W-1:0] w_code, w_mask;
  logic [SIZE_W-1:0] w_size;
  logic [ACC_W-1:0]  w_code_ext, w_acc_base;
  logic [CNT_W-1:0]  w_cnt_base, w_shamt;
  logic [7:0]        w_top, w_byte;
  logic [BUS_W-1:0]  w_asm_ins;
  logic w_out_free, w_asm_full, w_asm_take, w_ext_rdy, w_stuff;
  logic w_emit_acc, w_emit_pad, w_ins_zero, w_emit, w_drained, w_flush_go;

  // Unused low bits of the pad byte become 1s; the accumulator keeps them 0.
  function automatic logic [7:0] pad_byte(input logic [7:0] top, input logic [CNT_W-1:0] n);
    return top | (8'hFF >> n);
  endfunction

  assign w_code     = fifo_rd_data[CODE_W+SIZE_W-1:SIZE_W];
  assign w_size     = fifo_rd_data[SIZE_W-1:0];
  assign w_mask     = ~({CODE_W{1'b1}} << w_size);
  assign w_code_ext = ACC_W'(w_code & w_mask);

  assign w_out_free = !d_qual || !halt;
  assign w_asm_full = (r_acnt_p2 == AC_W'(NB - 1));
  assign w_asm_take = r_vld_p1 && (!w_asm_full || w_out_free);
  assign w_ext_rdy  = !r_vld_p1 || w_asm_take;

  assign w_emit_acc = w_ext_rdy && !w_stuff && (r_cnt_p0 >= CNT_W'(8));
  assign w_emit_pad = w_ext_rdy && !w_stuff && (r_state == S_PAD) && (r_cnt_p0 != '0);
  assign w_ins_zero = w_ext_rdy && w_stuff;
  assign w_emit     = w_emit_acc || w_emit_pad || w_ins_zero;
  assign w_top      = r_acc_p0[ACC_W-1 -: 8];
  assign w_byte     = w_ins_zero ? 8'h00 : (w_emit_pad ? pad_byte(w_top, r_cnt_p0) : w_top);

  assign fifo_rd    = rst && (r_state == S_RUN) && !fifo_empty && (r_cnt_p0 <= CNT_W'(16));

  assign w_cnt_base = w_emit_acc ? r_cnt_p0 - CNT_W'(8) : r_cnt_p0;
  assign w_acc_base = w_emit_acc ? r_acc_p0 << 8 : r_acc_p0;
  assign w_shamt    = CNT_W'(ACC_W) - w_cnt_base - CNT_W'(w_size);

  // Byte slot index counts down from the MSB byte; NB is a power of two.
  assign w_asm_ins  = r_asm_p2 | (BUS_W'(r_byte_p1) << {r_acnt_p2 ^ AC_W'(NB - 1), 3'b000});
  assign w_drained  = !w_stuff && !r_vld_p1 && (r_cnt_p0 == '0);
  assign w_flush_go = (r_state == S_FLUSH) && w_drained && w_out_free;
  assign eof_out    = (w_flush_go && (r_acnt_p2 == '0)) || (r_last && d_qual && !halt);

`ifdef JPEG_BYTE_STUFF_EN
  logic r_stuff;
  assign w_stuff = r_stuff;
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst)                                             r_stuff <= 1'b0;
    else if (w_ins_zero)                                  r_stuff <= 1'b0;
    else if ((w_emit_acc || w_emit_pad) && w_byte == 8'hFF) r_stuff <= 1'b1;
  end
`else
  assign w_stuff = 1'b0;
`endif

  // Stage p0: bit accumulator
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_acc_p0 <= '0;
      r_cnt_p0 <= '0;
    end else if (w_emit_pad) begin
      r_acc_p0 <= '0;
      r_cnt_p0 <= '0;
    end else if (fifo_rd) begin
      r_acc_p0 <= w_acc_base | (w_code_ext << w_shamt);
      r_cnt_p0 <= w_cnt_base + CNT_W'(w_size);
    end else begin
      r_acc_p0 <= w_acc_base;
      r_cnt_p0 <= w_cnt_base;
    end
  end

  // Stage p1: extracted byte
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_byte_p1 <= '0;
      r_vld_p1  <= 1'b0;
    end else if (w_emit) begin
      r_byte_p1 <= w_byte;
      r_vld_p1  <= 1'b1;
    end else if (w_asm_take) begin
      r_vld_p1  <= 1'b0;
    end
  end

  // Stage p2: word assembler feeding the output register
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_asm_p2   <= '0;
      r_acnt_p2  <= '0;
      write_data <= '0;
      write_be   <= '0;
      d_qual     <= 1'b0;
      r_last     <= 1'b0;
    end else begin
      if (d_qual && !halt) begin
        d_qual <= 1'b0;
        r_last <= 1'b0;
      end
      if (w_asm_take) begin
        if (w_asm_full) begin
          write_data <= w_asm_ins;
          write_be   <= '1;
          d_qual     <= 1'b1;
          r_asm_p2   <= '0;
          r_acnt_p2  <= '0;
        end else begin
          r_asm_p2  <= w_asm_ins;
          r_acnt_p2 <= r_acnt_p2 + AC_W'(1);
        end
      end else if (w_flush_go && (r_acnt_p2 != '0)) begin
        write_data <= r_asm_p2;
        write_be   <= ~({NB{1'b1}} >> r_acnt_p2);
        d_qual     <= 1'b1;
        r_last     <= 1'b1;
        r_asm_p2   <= '0;
        r_acnt_p2  <= '0;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_state <= S_RUN;
    end else begin
      case (r_state)
        S_RUN:   if (eof_in && fifo_empty && (r_cnt_p0 < CNT_W'(8))) r_state <= S_PAD;
        S_PAD:   if (w_emit_pad || (!w_stuff && (r_cnt_p0 == '0)))  r_state <= S_FLUSH;
        S_FLUSH: if (w_flush_go)                                     r_state <= S_DONE;
        default: if (!eof_in)                                        r_state <= S_RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_jpeg_stream_packer.sv
// Directed bench for jpeg_stream_packer: 32-bit and 64-bit instances fed from small FIFO models.
module tb_jpeg_stream_packer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   nchk = 0, npass = 0, nfail = 0;

  // 32-bit instance and its FIFO model
  logic [32:0] mem_a [0:63];
  int          wp_a = 0, rp_a = 0;
  logic [32:0] rdd_a;
  logic        emp_a, rd_a, eof_a, halt_a;
  logic [31:0] wd_a;
  logic [3:0]  be_a;
  logic        dq_a, eo_a;

  assign emp_a = (rp_a == wp_a);
  assign rdd_a = mem_a[rp_a[5:0]];

  always @(posedge clk or negedge rst_n)
    if (!rst_n)    rp_a <= wp_a;
    else if (rd_a) rp_a <= rp_a + 1;

  jpeg_stream_packer #(.BUS_W(32), .CODE_W(28), .SIZE_W(5)) dut_a (
    .clk_in(clk), .rst(rst_n), .fifo_rd_data(rdd_a), .fifo_empty(emp_a), .fifo_rd(rd_a),
    .eof_in(eof_a), .halt(halt_a), .write_data(wd_a), .write_be(be_a), .d_qual(dq_a),
    .eof_out(eo_a));

  logic [31:0] got_d   [0:15];
  logic [3:0]  got_be  [0:15];
  logic        got_eof [0:15];
  int          nw = 0, ne = 0, bad_eof = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (dq_a && !halt_a) begin
        got_d[nw[3:0]]   <= wd_a;
        got_be[nw[3:0]]  <= be_a;
        got_eof[nw[3:0]] <= eo_a;
        nw <= nw + 1;
      end
      if (eo_a) ne <= ne + 1;
      if (eo_a && dq_a && halt_a) bad_eof <= bad_eof + 1;
    end
  end

  // 64-bit instance
  logic [32:0] mem_b [0:63];
  int          wp_b = 0, rp_b = 0;
  logic [32:0] rdd_b;
  logic        emp_b, rd_b, eof_b;
  logic [63:0] wd_b, got_b;
  logic [7:0]  be_b, gotbe_b;
  logic        dq_b, eo_b;
  int          nw_b = 0;

  assign emp_b = (rp_b == wp_b);
  assign rdd_b = mem_b[rp_b[5:0]];

  always @(posedge clk or negedge rst_n)
    if (!rst_n)    rp_b <= wp_b;
    else if (rd_b) rp_b <= rp_b + 1;

  jpeg_stream_packer #(.BUS_W(64), .CODE_W(28), .SIZE_W(5)) dut_b (
    .clk_in(clk), .rst(rst_n), .fifo_rd_data(rdd_b), .fifo_empty(emp_b), .fifo_rd(rd_b),
    .eof_in(eof_b), .halt(1'b0), .write_data(wd_b), .write_be(be_b), .d_qual(dq_b),
    .eof_out(eo_b));

  always @(negedge clk)
    if (rst_n && dq_b) begin
      got_b   <= wd_b;
      gotbe_b <= be_b;
      nw_b    <= nw_b + 1;
    end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [27:0] c, input logic [4:0] s);
    mem_a[wp_a[5:0]] = {c, s};
    wp_a = wp_a + 1;
  endtask

  task automatic push_b(input logic [27:0] c, input logic [4:0] s);
    mem_b[wp_b[5:0]] = {c, s};
    wp_b = wp_b + 1;
  endtask

  task automatic wait_words(input int target, input string tag);
    int k = 0;
    while (nw < target && k < 200) begin tick(1); k++; end
    chk(tag, 64'(nw >= target), 64'd1);
  endtask

  task automatic wait_eofs(input int target, input string tag);
    int k = 0;
    while (ne < target && k < 200) begin tick(1); k++; end
    chk(tag, 64'(ne >= target), 64'd1);
  endtask

  logic [31:0] h_d;
  logic [3:0]  h_be;
  logic        stable;
  logic [3:0]  be_ff01, be_7f;

  initial begin
`ifdef JPEG_BYTE_STUFF_EN
    be_ff01 = 4'b1110;
    be_7f   = 4'b1100;
`else
    be_ff01 = 4'b1100;
    be_7f   = 4'b1000;
`endif
    rst_n = 1'b0; eof_a = 1'b0; halt_a = 1'b0; eof_b = 1'b0;
    tick(3);
    chk("rst_data", 64'(wd_a), 64'd0);
    chk("rst_be",   64'(be_a), 64'd0);
    chk("rst_dq",   64'(dq_a), 64'd0);
    chk("rst_eof",  64'(eo_a), 64'd0);
    chk("rst_rd",   64'(rd_a), 64'd0);
    rst_n = 1'b1;
    tick(2);

    // Full word from four bytes
    push_a(28'hAB, 5'd8); push_a(28'hCD, 5'd8); push_a(28'h12, 5'd8); push_a(28'h34, 5'd8);
    wait_words(1, "w1_timeout");
    chk("w1_data", 64'(got_d[0]), 64'hABCD1234);
    chk("w1_be",   64'(got_be[0]), 64'hF);
    tick(10);
    chk("w1_single_qual", 64'(nw), 64'd1);

    // 0xFF followed by 0x01, then end of frame
    push_a(28'hFF, 5'd8); push_a(28'h01, 5'd8);
    eof_a = 1'b1;
    wait_eofs(1, "ff_eof_timeout");
    chk("ff_words", 64'(nw), 64'd2);
`ifdef JPEG_BYTE_STUFF_EN
    chk("ff_data", 64'(got_d[1]), 64'hFF000100);
`else
    chk("ff_data", 64'(got_d[1]), 64'hFF010000);
`endif
    chk("ff_be",   64'(got_be[1]), 64'(be_ff01));
    chk("ff_eof_with_word", 64'(got_eof[1]), 64'd1);
    tick(3);
    chk("ff_single_eof", 64'(ne), 64'd1);
    eof_a = 1'b0;
    tick(3);

    // Three bits padded with ones
    push_a(28'h5, 5'd3);
    eof_a = 1'b1;
    wait_eofs(2, "pad3_timeout");
    chk("pad3_data", 64'(got_d[2]), 64'hBF000000);
    chk("pad3_be",   64'(got_be[2]), 64'h8);
    eof_a = 1'b0;
    tick(3);

    // Seven ones padded to 0xFF
    push_a(28'h7F, 5'd7);
    eof_a = 1'b1;
    wait_eofs(3, "pad7_timeout");
    chk("pad7_data", 64'(got_d[3]), 64'hFF000000);
    chk("pad7_be",   64'(got_be[3]), 64'(be_7f));
    eof_a = 1'b0;
    tick(3);

    // Reset with 13 bits in flight
    push_a(28'h1ABC, 5'd13);
    tick(2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_data", 64'(wd_a), 64'd0);
    chk("mid_rst_be",   64'(be_a), 64'd0);
    chk("mid_rst_dq",   64'(dq_a), 64'd0);
    chk("mid_rst_eof",  64'(eo_a), 64'd0);
    chk("mid_rst_rd",   64'(rd_a), 64'd0);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    push_a(28'h11, 5'd8); push_a(28'h22, 5'd8); push_a(28'h33, 5'd8); push_a(28'h44, 5'd8);
    wait_words(5, "post_rst_timeout");
    chk("post_rst_data", 64'(got_d[4]), 64'h11223344);
    chk("post_rst_be",   64'(got_be[4]), 64'hF);
    tick(10);
    chk("post_rst_words", 64'(nw), 64'd5);

    // Halt holds the output; pipeline fills and stops popping
    halt_a = 1'b1;
    for (int i = 1; i <= 12; i++) push_a(28'(i), 5'd8);
    begin
      int k = 0;
      while (!dq_a && k < 50) begin tick(1); k++; end
    end
    chk("halt_qual", 64'(dq_a), 64'd1);
    h_d = wd_a; h_be = be_a; stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      if (wd_a !== h_d || be_a !== h_be || dq_a !== 1'b1) stable = 1'b0;
    end
    chk("halt_stable", 64'(stable), 64'd1);
    chk("halt_word", 64'(h_d), 64'h01020304);
    tick(4);
    chk("halt_fifo_rd", 64'(rd_a), 64'd0);
    chk("halt_fifo_nonempty", 64'(emp_a), 64'd0);
    chk("halt_no_transfer", 64'(nw), 64'd5);
    halt_a = 1'b0;
    wait_words(8, "burst_timeout");
    chk("burst_w0", 64'(got_d[5]), 64'h01020304);
    chk("burst_w1", 64'(got_d[6]), 64'h05060708);
    chk("burst_w2", 64'(got_d[7]), 64'h090A0B0C);
    chk("burst_be", 64'({got_be[5], got_be[6], got_be[7]}), 64'hFFF);

    // 64-bit bus with interleaved size-0 entries
    for (int i = 1; i <= 8; i++) begin
      push_b(28'(i * 17), 5'd8);
      push_b(28'hFFFFFFF, 5'd0);
    end
    begin
      int k = 0;
      while (nw_b < 1 && k < 100) begin tick(1); k++; end
    end
    chk("b64_words", 64'(nw_b), 64'd1);
    chk("b64_data",  got_b, 64'h1122334455667788);
    chk("b64_be",    64'(gotbe_b), 64'hFF);

    chk("eof_never_halted", 64'(bad_eof), 64'd0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
